score_player: RTL and testbench
===============================

SCORE_PLAYER -- requirements
Module: score_player

Interface
REQ-001 SHALL have parameter DataLength, default 4, width of key and time fields.
REQ-002 SHALL have parameter AddressBits, default 5, width of the score address.
REQ-003 SHALL have parameter SegmentLength, default 12, maximum entries played per piece.
REQ-004 SHALL have ports: Clock  in  1  system clock, rising-edge; Reset  in  1  asynchronous, active-high.
REQ-005 SHALL have port Start  in  1  begin playback, sampled in IDLE only.
REQ-006 SHALL have port Stop  in  1  abort playback and return to IDLE.
REQ-007 SHALL have port ChoiceIn  in  2  piece select, captured at Start.
REQ-008 SHALL have port BeatTick  in  1  one-cycle pulse per time unit.
REQ-009 SHALL have port KeyIn  in  DataLength  key read from score memory, registered, valid one cycle after Address.
REQ-010 SHALL have port TimeIn  in  DataLength  duration read from score memory, same timing as KeyIn.
REQ-011 SHALL have ports: Address  out  AddressBits  score index; ReadOrWrite  out  1  memory read strobe, constant 1; Choice  out  2  latched piece select.
REQ-012 SHALL have ports: Key  out  DataLength  current note; NoteValid  out  1  audible note playing; Busy  out  1  playback active; Done  out  1  one-cycle end-of-piece pulse.

Function
REQ-013 SHALL implement states IDLE, FETCH, CHECK, PLAY, DONE.
REQ-014 IDLE: Start=1 and Stop=0 SHALL latch Choice<=ChoiceIn, Address<=0, next state FETCH.
REQ-015 FETCH: Address stable, one cycle, next state CHECK; memory captures data at the end of this cycle.
REQ-016 CHECK: TimeIn==0 SHALL go to DONE (end marker, regardless of KeyIn).
REQ-017 CHECK: TimeIn!=0 SHALL load Key<=KeyIn, Remaining<=TimeIn, next state PLAY.
REQ-018 PLAY: each BeatTick SHALL decrement Remaining; the tick decrementing 1->0 SHALL end the note.
REQ-019 At note end: if Address==SegmentLength-1, next state DONE; else Address<=Address+1, next state FETCH.
REQ-020 Fetch overhead SHALL be exactly 2 cycles (FETCH, CHECK) between notes; BeatTicks in those cycles are ignored.
REQ-021 DONE: Done=1 for exactly one cycle, next state IDLE; Key<=0.
REQ-022 Key SHALL be 0 in IDLE, FETCH, CHECK and DONE; Key holds the loaded value through PLAY.
REQ-023 NoteValid SHALL be 1 only in PLAY with Key!=0; Key==0 with Time>0 is a rest (NoteValid=0, duration still counted).
REQ-024 Busy SHALL be 1 in FETCH, CHECK, PLAY, DONE; 0 in IDLE.
REQ-025 Stop=1 in any state SHALL force IDLE next cycle, Key<=0, no Done pulse; Stop beats Start when simultaneous.
REQ-026 Start while Busy=1 SHALL be ignored; ChoiceIn changes while Busy SHALL not affect Choice.
REQ-027 BeatTick outside PLAY SHALL have no effect; Remaining is DataLength bits, never wraps below 0.
REQ-028 Address SHALL never exceed SegmentLength-1.

Reset
REQ-029 Reset=1 SHALL asynchronously force state IDLE, Address=0, Choice=0, Key=0, Remaining=0, NoteValid=0, Busy=0, Done=0; ReadOrWrite stays 1.
REQ-030 Reset asserted mid-PLAY SHALL abort immediately with no Done pulse; playback resumes only on a new Start after release.

Verification
REQ-031 Score {K1 T2, K3 T1, K0 T0}, Start, ticks every 4 cycles -> Key=1 for 2 ticks, Key=3 for 1 tick, Done pulse once, Address sequence 0,1,2, Busy drops after Done.
REQ-032 Entry K0 T3 -> Key=0, NoteValid=0, Busy=1 for 3 ticks, then next fetch.
REQ-033 12 entries all T1, no end marker -> Done after 12th note, Address peaks at 11, never 12.
REQ-034 Stop asserted in PLAY with Remaining=2 -> IDLE next cycle, Key=0, Done never pulses; Start and Stop together in IDLE -> stays IDLE.
REQ-035 ChoiceIn=2 at Start then ChoiceIn=1 during play -> Choice remains 2; second Start during play ignored.
REQ-036 Reset pulse during PLAY between clock edges -> all outputs 0 immediately, state IDLE; BeatTick during FETCH/CHECK does not shorten the next note.

Source files
------------

// File: rtl/score_player.sv
// Score playback sequencer: walks a score memory entry by entry, holding each
// key for its duration in beat ticks until an end marker or the segment limit.
module score_player #(
  parameter int DataLength    = 4,
  parameter int AddressBits   = 5,
  parameter int SegmentLength = 12
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Stop,
  input  logic [1:0]             ChoiceIn,
  input  logic                   BeatTick,
  input  logic [DataLength-1:0]  KeyIn,
  input  logic [DataLength-1:0]  TimeIn,
  output logic [AddressBits-1:0] Address,
  output logic                   ReadOrWrite,
  output logic [1:0]             Choice,
  output logic [DataLength-1:0]  Key,
  output logic                   NoteValid,
  output logic                   Busy,
  output logic                   Done
);

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, PLAY, DONE} state_t;

  localparam logic [AddressBits-1:0] LastAddress = AddressBits'(SegmentLength - 1);
  localparam logic [DataLength-1:0]  OneBeat     = DataLength'(1);

  state_t                state;
  logic [DataLength-1:0] remaining;

  assign ReadOrWrite = 1'b1;

  // All outputs are registered and updated together with the state transition.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      Address   <= '0;
      Choice    <= '0;
      Key       <= '0;
      remaining <= '0;
      NoteValid <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else if (Stop) begin
      state     <= IDLE;
      Address   <= '0;
      Key       <= '0;
      remaining <= '0;
      NoteValid <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            Choice  <= ChoiceIn;
            Address <= '0;
            Busy    <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: state <= CHECK;
        CHECK: begin
          // A zero duration marks the end of the piece whatever the key is.
          if (TimeIn == '0) begin
            Done  <= 1'b1;
            state <= DONE;
          end else begin
            Key       <= KeyIn;
            remaining <= TimeIn;
            NoteValid <= (KeyIn != '0);
            state     <= PLAY;
          end
        end
        PLAY: begin
          if (BeatTick && remaining != '0) begin
            remaining <= remaining - OneBeat;
            if (remaining == OneBeat) begin
              Key       <= '0;
              NoteValid <= 1'b0;
              if (Address == LastAddress) begin
                Done  <= 1'b1;
                state <= DONE;
              end else begin
                Address <= Address + 1'b1;
                state   <= FETCH;
              end
            end
          end
        end
        DONE: begin
          Key   <= '0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_player.sv
// Directed bench for score_player with a registered score memory model.
module tb_score_player;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start, Stop, BeatTick;
  logic [1:0] ChoiceIn;
  logic [3:0] KeyIn, TimeIn;
  logic [4:0] Address;
  logic       ReadOrWrite;
  logic [1:0] Choice;
  logic [3:0] Key;
  logic       NoteValid, Busy, Done;

  logic [3:0] mem_key  [32];
  logic [3:0] mem_time [32];
  logic [4:0] max_addr;

  int errors = 0;
  int checks = 0;

  score_player #(.DataLength(4), .AddressBits(5), .SegmentLength(12)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop),
    .ChoiceIn(ChoiceIn), .BeatTick(BeatTick), .KeyIn(KeyIn), .TimeIn(TimeIn),
    .Address(Address), .ReadOrWrite(ReadOrWrite), .Choice(Choice),
    .Key(Key), .NoteValid(NoteValid), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  // Registered read: data for Address appears one cycle later.
  always @(posedge Clock) begin
    KeyIn  <= mem_key[Address];
    TimeIn <= mem_time[Address];
    if (Address > max_addr) max_addr <= Address;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic beat();
    BeatTick = 1'b1;
    step();
    BeatTick = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) begin
      mem_key[i]  = 4'd0;
      mem_time[i] = 4'd0;
    end
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_key"},  32'(Key), 0);
    chk({tag, "_nv"},   32'(NoteValid), 0);
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_done"}, 32'(Done), 0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; BeatTick = 1'b0; ChoiceIn = 2'd0;
    max_addr = '0;
    clear_mem();
    #2;
    outs_zero("reset");
    chk("reset_addr", 32'(Address), 0);
    chk("reset_choice", 32'(Choice), 0);
    chk("reset_rw", 32'(ReadOrWrite), 1);
    #10 Reset = 1'b0;

    // Three-entry score with end marker, ticks every 4 cycles
    mem_key[0] = 4'd1; mem_time[0] = 4'd2;
    mem_key[1] = 4'd3; mem_time[1] = 4'd1;
    mem_key[2] = 4'd0; mem_time[2] = 4'd0;
    ChoiceIn = 2'd1; Start = 1'b1;
    step(); Start = 1'b0;
    chk("t1_fetch_busy", 32'(Busy), 1);
    chk("t1_fetch_addr", 32'(Address), 0);
    chk("t1_fetch_key", 32'(Key), 0);
    chk("t1_choice", 32'(Choice), 1);
    step();
    chk("t1_check_key", 32'(Key), 0);
    step();
    chk("t1_play_key", 32'(Key), 1);
    chk("t1_play_nv", 32'(NoteValid), 1);
    repeat (3) step(); beat();
    chk("t1_after1tick_key", 32'(Key), 1);
    repeat (3) step(); beat();
    chk("t1_note2_fetch_addr", 32'(Address), 1);
    chk("t1_note2_fetch_key", 32'(Key), 0);
    chk("t1_note2_fetch_busy", 32'(Busy), 1);
    step(); step();
    chk("t1_note2_key", 32'(Key), 3);
    repeat (3) step(); beat();
    chk("t1_end_fetch_addr", 32'(Address), 2);
    step(); step();
    chk("t1_done", 32'(Done), 1);
    chk("t1_done_busy", 32'(Busy), 1);
    chk("t1_done_key", 32'(Key), 0);
    step();
    chk("t1_idle_done", 32'(Done), 0);
    chk("t1_idle_busy", 32'(Busy), 0);
    repeat (3) step();
    chk("t1_done_once", 32'(Done), 0);

    // Rest entry, plus ticks held through FETCH/CHECK
    clear_mem();
    mem_key[0] = 4'd0; mem_time[0] = 4'd3;
    mem_key[1] = 4'd5; mem_time[1] = 4'd2;
    Start = 1'b1; step(); Start = 1'b0;
    step(); step();
    chk("t2_rest_key", 32'(Key), 0);
    chk("t2_rest_nv", 32'(NoteValid), 0);
    chk("t2_rest_busy", 32'(Busy), 1);
    beat(); beat();
    chk("t2_rest_still_addr", 32'(Address), 0);
    chk("t2_rest_still_busy", 32'(Busy), 1);
    BeatTick = 1'b1; step();
    chk("t2_next_fetch_addr", 32'(Address), 1);
    step(); step();
    BeatTick = 1'b0;
    chk("t2_note_key", 32'(Key), 5);
    chk("t2_note_nv", 32'(NoteValid), 1);
    beat();
    chk("t2_not_shortened", 32'(Key), 5);
    beat();
    chk("t2_note_end_addr", 32'(Address), 2);
    step(); step();
    chk("t2_done", 32'(Done), 1);
    step();

    // Twelve one-beat entries with no end marker
    clear_mem();
    for (int i = 0; i < 32; i++) begin
      mem_key[i]  = (i < 12) ? 4'(i + 1) : 4'd7;
      mem_time[i] = (i < 12) ? 4'd1 : 4'd5;
    end
    max_addr = '0;
    Start = 1'b1; step(); Start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t3_fetch_addr%0d", i), 32'(Address), 32'(i));
      step(); step();
      chk($sformatf("t3_key%0d", i), 32'(Key), 32'(i + 1));
      beat();
    end
    chk("t3_done", 32'(Done), 1);
    chk("t3_done_addr", 32'(Address), 11);
    step();
    chk("t3_idle_busy", 32'(Busy), 0);
    chk("t3_max_addr", 32'(max_addr), 11);

    // Stop mid-note, then Start with Stop in IDLE
    clear_mem();
    mem_key[0] = 4'd2; mem_time[0] = 4'd3;
    Start = 1'b1; step(); Start = 1'b0;
    step(); step();
    chk("t4_play_key", 32'(Key), 2);
    beat();
    Stop = 1'b1; step(); Stop = 1'b0;
    outs_zero("t4_stop");
    repeat (3) step();
    chk("t4_no_done", 32'(Done), 0);
    Start = 1'b1; Stop = 1'b1; step();
    Start = 1'b0; Stop = 1'b0;
    chk("t4_startstop_busy", 32'(Busy), 0);
    step();
    chk("t4_startstop_idle", 32'(Busy), 0);

    // Choice latching, ignored second Start
    mem_key[0] = 4'd4; mem_time[0] = 4'd2;
    ChoiceIn = 2'd2; Start = 1'b1; step(); Start = 1'b0;
    ChoiceIn = 2'd1;
    step(); step();
    chk("t5_key", 32'(Key), 4);
    Start = 1'b1; step(); Start = 1'b0;
    chk("t5_choice", 32'(Choice), 2);
    chk("t5_key_after_start", 32'(Key), 4);
    chk("t5_addr", 32'(Address), 0);
    chk("t5_busy", 32'(Busy), 1);

    // Asynchronous reset between edges during PLAY
    #2 Reset = 1'b1;
    #1;
    outs_zero("t6_async");
    chk("t6_addr", 32'(Address), 0);
    chk("t6_choice", 32'(Choice), 0);
    chk("t6_rw", 32'(ReadOrWrite), 1);
    #1 Reset = 1'b0;
    repeat (3) step();
    chk("t6_no_resume_busy", 32'(Busy), 0);
    chk("t6_no_done", 32'(Done), 0);
    Start = 1'b1; step(); Start = 1'b0;
    chk("t6_restart_busy", 32'(Busy), 1);
    chk("t6_restart_choice", 32'(Choice), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
